// File: rtl/cargador_mascara.sv
// Mask coefficient loader: on a start pulse, reads N*N coefficients from a
// 1-cycle synchronous memory into a flat row-major register bank.
module cargador_mascara #(
    parameter int BITS_DIRECCION_MEM = 10,
    parameter int BITS_MASCARA       = 3,
    parameter int BITS_COEFICIENTE   = 8,
    parameter int MAX_TAMANO         = 5
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 inicio_carga,
    input  logic [BITS_DIRECCION_MEM-1:0]                        direccion_mem_inicio_mascara,
    input  logic [BITS_MASCARA-1:0]                              tamano_mascara,
    output logic [BITS_DIRECCION_MEM-1:0]                        mem_direccion,
    output logic                                                 mem_lectura,
    input  logic [BITS_COEFICIENTE-1:0]                          mem_datos,
    output logic [MAX_TAMANO*MAX_TAMANO*BITS_COEFICIENTE-1:0]    coeficientes,
    output logic                                                 mascara_lista,
    output logic                                                 ocupado,
    output logic                                                 error_tamano
);

    localparam int unsigned ENTRADAS   = MAX_TAMANO * MAX_TAMANO;
    localparam int          BITS_TOTAL = $clog2(ENTRADAS + 1);

    typedef enum logic [1:0] {
        REPOSO,
        LEER,
        ULTIMO
    } estado_t;

    estado_t                       estado, estado_sig;
    logic [BITS_DIRECCION_MEM-1:0] base;
    logic [BITS_TOTAL-1:0]         total;
    logic [BITS_TOTAL-1:0]         k;
    logic [BITS_TOTAL-1:0]         total_nuevo;
    logic                          tamano_ilegal;
    logic [BITS_COEFICIENTE-1:0]   banco [ENTRADAS];

    assign tamano_ilegal = (tamano_mascara == '0) || (int'(tamano_mascara) > MAX_TAMANO);
    assign total_nuevo   = BITS_TOTAL'(tamano_mascara) * BITS_TOTAL'(tamano_mascara);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig    = estado;
        mem_lectura   = 1'b0;
        mem_direccion = '0;
        ocupado       = 1'b0;
        case (estado)
            REPOSO: begin
                if (inicio_carga && !tamano_ilegal) begin
                    estado_sig = LEER;
                end
            end
            LEER: begin
                ocupado       = 1'b1;
                mem_lectura   = 1'b1;
                mem_direccion = base + BITS_DIRECCION_MEM'(k);
                if (k == total - BITS_TOTAL'(1)) begin
                    estado_sig = ULTIMO;
                end
            end
            ULTIMO: begin
                ocupado    = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // k runs one ahead of the datum on mem_datos, so capture always targets k-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base          <= '0;
            total         <= '0;
            k             <= '0;
            mascara_lista <= 1'b0;
            error_tamano  <= 1'b0;
            for (int unsigned i = 0; i < ENTRADAS; i++) begin
                banco[i] <= '0;
            end
        end else begin
            case (estado)
                REPOSO: begin
                    if (inicio_carga) begin
                        if (tamano_ilegal) begin
                            error_tamano <= 1'b1;
                        end else begin
                            base          <= direccion_mem_inicio_mascara;
                            total         <= total_nuevo;
                            k             <= '0;
                            error_tamano  <= 1'b0;
                            mascara_lista <= 1'b0;
                            for (int unsigned i = 0; i < ENTRADAS; i++) begin
                                if (i >= 32'(total_nuevo)) begin
                                    banco[i] <= '0;
                                end
                            end
                        end
                    end
                end
                LEER: begin
                    k <= k + BITS_TOTAL'(1);
                    if (k != '0) begin
                        banco[k - BITS_TOTAL'(1)] <= mem_datos;
                    end
                end
                ULTIMO: begin
                    banco[k - BITS_TOTAL'(1)] <= mem_datos;
                    mascara_lista             <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        coeficientes = '0;
        for (int unsigned i = 0; i < ENTRADAS; i++) begin
            coeficientes[i*BITS_COEFICIENTE +: BITS_COEFICIENTE] = banco[i];
        end
    end

endmodule

// File: tb/tb_cargador_mascara.sv
// Scoreboard bench for cargador_mascara: stimulus pushes expected reads and
// banks into queues, a negedge monitor pops and compares them.
module tb_cargador_mascara;

    localparam int AW = 10;
    localparam int NW = 3;
    localparam int CW = 8;
    localparam int MX = 5;
    localparam int BW = MX * MX * CW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          inicio_carga = 1'b0;
    logic [AW-1:0] dir_inicio = '0;
    logic [NW-1:0] tamano = '0;
    logic [AW-1:0] mem_direccion;
    logic          mem_lectura;
    logic [CW-1:0] mem_datos = '0;
    logic [BW-1:0] coeficientes;
    logic          mascara_lista;
    logic          ocupado;
    logic          error_tamano;

    cargador_mascara #(
        .BITS_DIRECCION_MEM(AW),
        .BITS_MASCARA(NW),
        .BITS_COEFICIENTE(CW),
        .MAX_TAMANO(MX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inicio_carga(inicio_carga),
        .direccion_mem_inicio_mascara(dir_inicio),
        .tamano_mascara(tamano),
        .mem_direccion(mem_direccion),
        .mem_lectura(mem_lectura),
        .mem_datos(mem_datos),
        .coeficientes(coeficientes),
        .mascara_lista(mascara_lista),
        .ocupado(ocupado),
        .error_tamano(error_tamano)
    );

    always #5 clk = ~clk;

    logic [CW-1:0] mem [1024];
    always @(posedge clk) if (mem_lectura) mem_datos <= mem[mem_direccion];

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW-1:0] q_addr [$];
    logic [BW-1:0] q_bank [$];
    int            q_lat  [$];

    logic [BW-1:0] model_bank  = '0;
    logic          model_lista = 1'b0;
    logic          model_err   = 1'b0;

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: every read address, every completed load's latency and bank.
    int   nbusy = 0;
    int   nreads = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            nbusy = 0; nreads = 0; prev_busy = 1'b0;
        end else begin
            if (mem_lectura) begin
                nreads++;
                if (q_addr.size() == 0) check("unexpected_read", BW'(mem_direccion), BW'(0) - 1);
                else check("read_addr", BW'(mem_direccion), BW'(q_addr.pop_front()));
            end
            if (ocupado) begin
                nbusy++;
                check("lista_low_while_busy", BW'(mascara_lista), BW'(0));
            end
            if (prev_busy && !ocupado) begin
                if (q_lat.size() == 0 || q_bank.size() == 0) begin
                    check("unexpected_completion", BW'(1), BW'(0));
                end else begin
                    automatic int lat = q_lat.pop_front();
                    check("latency", BW'(nbusy), BW'(lat));
                    check("read_count", BW'(nreads), BW'(lat - 1));
                    check("lista_on_done", BW'(mascara_lista), BW'(1));
                    check("bank", coeficientes, q_bank.pop_front());
                end
                nbusy = 0; nreads = 0;
            end
            prev_busy = ocupado;
        end
    end

    // Start a load from idle; the model decides legality and the resulting bank.
    task automatic cargar(input logic [AW-1:0] b, input int n);
        automatic int total = n * n;
        automatic bit ilegal = (n == 0) || (n > MX);
        @(negedge clk);
        inicio_carga = 1'b1; dir_inicio = b; tamano = n[NW-1:0];
        if (ilegal) begin
            model_err = 1'b1;
        end else begin
            model_bank = '0;
            for (int i = 0; i < total; i++) begin
                q_addr.push_back(AW'(b + AW'(i)));
                model_bank[i*CW +: CW] = mem[AW'(b + AW'(i))];
            end
            q_bank.push_back(model_bank);
            q_lat.push_back(total + 1);
            model_err   = 1'b0;
            model_lista = 1'b1;
        end
        @(negedge clk);
        inicio_carga = 1'b0;
        check("error_flag", BW'(error_tamano), BW'(model_err));
        check("busy_after_start", BW'(ocupado), BW'(!ilegal));
        if (ilegal) begin
            check("bank_kept", coeficientes, model_bank);
            check("lista_kept", BW'(mascara_lista), BW'(model_lista));
        end else begin
            check("lista_cleared", BW'(mascara_lista), BW'(0));
        end
    endtask

    task automatic pulso_ignorado(input logic [AW-1:0] b, input int n);
        @(negedge clk);
        inicio_carga = 1'b1; dir_inicio = b; tamano = n[NW-1:0];
        @(negedge clk);
        inicio_carga = 1'b0;
    endtask

    task automatic esperar_reposo();
        automatic bit hecho = 1'b0;
        for (int c = 0; c < 60 && !hecho; c++) begin
            @(negedge clk);
            if (!ocupado) hecho = 1'b1;
        end
        if (!hecho) check("idle_timeout", BW'(0), BW'(1));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_bank"}, coeficientes, '0);
        check({name, "_ctrl"},
              BW'({mascara_lista, ocupado, error_tamano, mem_lectura, mem_direccion}), BW'(0));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = CW'(i);
        #12;
        check_reset_outputs("reset");
        @(negedge clk); reset = 1'b1;

        cargar(10'h010, 3); esperar_reposo();
        cargar(10'h3FE, 2); esperar_reposo();

        cargar(10'h100, 0); repeat (3) @(negedge clk);
        check("no_read_illegal0", BW'(q_addr.size()), BW'(0));
        cargar(10'h100, 6); repeat (3) @(negedge clk);
        check("bank_after_illegal", coeficientes, model_bank);
        cargar(10'h055, 1); esperar_reposo();

        cargar(10'h020, 3); repeat (2) @(negedge clk);
        pulso_ignorado(10'h200, 4); esperar_reposo();

        cargar(10'h080, 5); repeat (4) @(negedge clk);
        @(posedge clk); #1 reset = 1'b0;
        #1 check_reset_outputs("async_reset");
        q_addr.delete(); q_bank.delete(); q_lat.delete();
        model_bank = '0; model_lista = 1'b0; model_err = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cargar(10'h0C0, 2); esperar_reposo();

        cargar(10'h140, 5); esperar_reposo();
        cargar(10'h1A0, 2); esperar_reposo();

        for (int it = 0; it < 30; it++) begin
            automatic int n = $urandom_range(0, 7);
            automatic logic [AW-1:0] b = AW'($urandom);
            if (it % 5 == 0) for (int i = 0; i < 1024; i++) mem[i] = CW'($urandom);
            cargar(b, n);
            if (n >= 1 && n <= MX) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(0, n * n - 1)) @(negedge clk);
                    pulso_ignorado(AW'($urandom), $urandom_range(0, 7));
                end
                esperar_reposo();
            end else begin
                @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("pending_reads", BW'(q_addr.size()), BW'(0));
        check("pending_loads", BW'(q_bank.size()), BW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
